// File: rtl/pc_redirect_tracker_if.sv
// pc_redirect_tracker_if
//   Bundles the decode-side inputs and the tracker outputs of
//   pc_redirect_tracker. The block itself connects through the slave modport.
//   The driver of the decode/pipeline controls connects through the master
//   modport.
//
//   Signals (direction as seen from the slave / tracker):
//     en           in   pipeline advance enable (0 = stall)
//     flush        in   bubble insert into stage 0
//     valid_d      in   decode-stage instruction valid
//     Rd           in   decode destination register
//     Branch       in   decode instruction is a branch
//     RegW         in   decode instruction writes a register
//     cond_ex      in   execute-stage condition passed
//     PCS          out  decode PC-write flag (combinational)
//     pcs_pipe     out  per-stage PC-write flags, bit 0 = execute
//     pc_busy      out  fetch stall / PC busy indication
//     pc_src_w     out  writeback stage loads the PC this cycle
//     redirect_cnt out  saturating count of committed redirects
interface pc_redirect_tracker_if #(
  parameter int REG_ADDR_W = 5,
  parameter int STAGES     = 3,
  parameter int CNT_W      = 16
);
  logic                  en;
  logic                  flush;
  logic                  valid_d;
  logic [REG_ADDR_W-1:0] Rd;
  logic                  Branch;
  logic                  RegW;
  logic                  cond_ex;
  logic                  PCS;
  logic [STAGES-1:0]     pcs_pipe;
  logic                  pc_busy;
  logic                  pc_src_w;
  logic [CNT_W-1:0]      redirect_cnt;

  modport master (
    output en, flush, valid_d, Rd, Branch, RegW, cond_ex,
    input  PCS, pcs_pipe, pc_busy, pc_src_w, redirect_cnt
  );

  modport slave (
    input  en, flush, valid_d, Rd, Branch, RegW, cond_ex,
    output PCS, pcs_pipe, pc_busy, pc_src_w, redirect_cnt
  );
endinterface

// File: rtl/pc_redirect_tracker.sv
// pc_redirect_tracker
//   Computes the decode-stage PC-write flag (PCS). The flag is carried through
//   STAGES pipeline registers, running from execute to writeback. The
//   pipeline supports stall (en=0), flush of stage 0, and cancellation when
//   the execute-stage condition check fails. The block drives:
//     - the fetch busy indication, and
//     - the writeback PC-source select.
//   It also keeps a saturating count of committed PC redirects.
//
//   Ports:
//     clk  in  system clock, rising edge
//     rst  in  asynchronous active-high reset
//     bus  pc_redirect_tracker_if.slave (see interface header for signals)
//
//   The parameters must match those of the connected interface instance.
//   STAGES must lie in 2..8 and PC_REG must be below 2**REG_ADDR_W.
module pc_redirect_tracker #(
  parameter int REG_ADDR_W = 5,
  parameter int PC_REG     = 15,
  parameter int STAGES     = 3,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  pc_redirect_tracker_if.slave    bus
);

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);
  localparam logic [CNT_W-1:0]      CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [STAGES-1:0] pipe_q, pipe_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pcs;

  // The decode flag does not depend on valid_d or en. This keeps it
  // truth-table identical to the older decode logic; gating by valid_d
  // happens only where it enters the pipeline.
  assign pcs = bus.Branch | (bus.RegW & (bus.Rd == PC_ADDR));

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_s0
        // Flush wins over a stall so that a bubble can be inserted while
        // the rest of the pipeline is frozen.
        assign pipe_d[gi] = bus.flush ? 1'b0 :
                            bus.en    ? (pcs & bus.valid_d) : pipe_q[gi];
      end else if (gi == 1) begin : g_s1
        // Entering memory stage: a failed condition check cancels the redirect.
        assign pipe_d[gi] = bus.en ? (pipe_q[0] & bus.cond_ex) : pipe_q[gi];
      end else begin : g_sk
        assign pipe_d[gi] = bus.en ? pipe_q[gi-1] : pipe_q[gi];
      end
    end
  endgenerate

  // A redirect held in writeback by a stall is counted only on the edge
  // where it actually leaves (en=1). The count therefore equals the number
  // of commits.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.en && pipe_q[STAGES-1] && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
      cnt_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.PCS          = pcs;
  assign bus.pcs_pipe     = pipe_q;
  // Busy covers a redirect in decode and every stage before writeback. The
  // writeback stage itself is signalled separately by pc_src_w.
  assign bus.pc_busy      = (pcs & bus.valid_d) | (|pipe_q[STAGES-2:0]);
  assign bus.pc_src_w     = pipe_q[STAGES-1];
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_tracker.sv
module tb_pc_redirect_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance uses default parameters. The second instance has a 2-bit
  // counter and sees the same stimulus, so that saturation can be observed.
  pc_redirect_tracker_if #(.REG_ADDR_W(5), .STAGES(3), .CNT_W(16)) bus ();
  pc_redirect_tracker_if #(.REG_ADDR_W(5), .STAGES(3), .CNT_W(2))  bus2 ();

  pc_redirect_tracker #(.REG_ADDR_W(5), .PC_REG(15), .STAGES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  pc_redirect_tracker #(.REG_ADDR_W(5), .PC_REG(15), .STAGES(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  typedef struct {
    string       name;
    logic        pcs;
    logic [2:0]  pipe;
    logic        busy;
    logic        src;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // One cycle of stimulus. Inputs are applied 1 time unit after the rising
  // edge. The expectation pushed here is the output seen before the next
  // edge: e_pipe/e_cnt are the registered state left by the previous edge.
  task automatic step(input string name, input logic r, input logic en,
                      input logic fl, input logic v, input logic [4:0] rd,
                      input logic br, input logic rw, input logic ce,
                      input logic e_pcs, input logic [2:0] e_pipe,
                      input logic e_busy, input logic e_src,
                      input logic [15:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus.en = en;      bus2.en = en;
    bus.flush = fl;   bus2.flush = fl;
    bus.valid_d = v;  bus2.valid_d = v;
    bus.Rd = rd;      bus2.Rd = rd;
    bus.Branch = br;  bus2.Branch = br;
    bus.RegW = rw;    bus2.RegW = rw;
    bus.cond_ex = ce; bus2.cond_ex = ce;
    e.name = name; e.pcs = e_pcs; e.pipe = e_pipe; e.busy = e_busy;
    e.src = e_src; e.cnt = e_cnt;
    e.cnt2 = (e_cnt > 16'd3) ? 2'd3 : e_cnt[1:0];
    sb.push_back(e);
  endtask

  // Monitor: compares the DUT outputs against the oldest expectation once
  // per cycle, on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (bus.PCS !== e.pcs || bus.pcs_pipe !== e.pipe || bus.pc_busy !== e.busy ||
          bus.pc_src_w !== e.src || bus.redirect_cnt !== e.cnt ||
          bus2.redirect_cnt !== e.cnt2 || bus2.pcs_pipe !== e.pipe) begin
        bad++;
        $display("FAIL %s: got pcs=%b pipe=%b busy=%b src=%b cnt=%0d cnt2=%0d pipe2=%b, want pcs=%b pipe=%b busy=%b src=%b cnt=%0d cnt2=%0d",
                 e.name, bus.PCS, bus.pcs_pipe, bus.pc_busy, bus.pc_src_w,
                 bus.redirect_cnt, bus2.redirect_cnt, bus2.pcs_pipe,
                 e.pcs, e.pipe, e.busy, e.src, e.cnt, e.cnt2);
      end else begin
        $display("ok   %s: pcs=%b pipe=%b busy=%b src=%b cnt=%0d cnt2=%0d",
                 e.name, bus.PCS, bus.pcs_pipe, bus.pc_busy, bus.pc_src_w,
                 bus.redirect_cnt, bus2.redirect_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.en = 0; bus.flush = 0; bus.valid_d = 0; bus.Rd = 0;
    bus.Branch = 0; bus.RegW = 0; bus.cond_ex = 0;
    bus2.en = 0; bus2.flush = 0; bus2.valid_d = 0; bus2.Rd = 0;
    bus2.Branch = 0; bus2.RegW = 0; bus2.cond_ex = 0;

    //   name          rst en fl v  rd     br rw ce | pcs pipe   busy src cnt
    step("reset",       1, 0, 0, 0, 5'd0,  0, 0, 0,   0, 3'b000, 0, 0, 0);
    // PCS truth table with valid_d=0, so nothing enters the pipeline.
    step("tt_rd0_00",   0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b000, 0, 0, 0);
    step("tt_rd0_10",   0, 1, 0, 0, 5'd0,  1, 0, 1,   1, 3'b000, 0, 0, 0);
    step("tt_rd0_01",   0, 1, 0, 0, 5'd0,  0, 1, 1,   0, 3'b000, 0, 0, 0);
    step("tt_rd0_11",   0, 1, 0, 0, 5'd0,  1, 1, 1,   1, 3'b000, 0, 0, 0);
    step("tt_rd15_00",  0, 1, 0, 0, 5'd15, 0, 0, 1,   0, 3'b000, 0, 0, 0);
    step("tt_rd15_10",  0, 1, 0, 0, 5'd15, 1, 0, 1,   1, 3'b000, 0, 0, 0);
    step("tt_rd15_01",  0, 1, 0, 0, 5'd15, 0, 1, 1,   1, 3'b000, 0, 0, 0);
    step("tt_rd15_11",  0, 1, 0, 0, 5'd15, 1, 1, 1,   1, 3'b000, 0, 0, 0);
    // Latency: one branch, pipeline free-running.
    step("lat_issue",   0, 1, 0, 1, 5'd0,  1, 0, 1,   1, 3'b000, 1, 0, 0);
    step("lat_ex",      0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b001, 1, 0, 0);
    step("lat_mem",     0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b010, 1, 0, 0);
    step("lat_wb",      0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b100, 0, 1, 0);
    step("lat_done",    0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b000, 0, 0, 1);
    // Condition fail in execute cancels the redirect.
    step("cxl_issue",   0, 1, 0, 1, 5'd0,  1, 0, 1,   1, 3'b000, 1, 0, 1);
    step("cxl_ex_fail", 0, 1, 0, 0, 5'd0,  0, 0, 0,   0, 3'b001, 1, 0, 1);
    step("cxl_gone",    0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b000, 0, 0, 1);
    step("cxl_nosrc",   0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b000, 0, 0, 1);
    // Stall with the flag in stage 1.
    step("stl_issue",   0, 1, 0, 1, 5'd0,  1, 0, 1,   1, 3'b000, 1, 0, 1);
    step("stl_ex",      0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b001, 1, 0, 1);
    step("stl_hold1",   0, 0, 0, 0, 5'd0,  0, 0, 1,   0, 3'b010, 1, 0, 1);
    step("stl_hold2",   0, 0, 0, 0, 5'd0,  0, 0, 1,   0, 3'b010, 1, 0, 1);
    step("stl_hold3",   0, 0, 0, 0, 5'd0,  0, 0, 1,   0, 3'b010, 1, 0, 1);
    step("stl_hold4",   0, 0, 0, 0, 5'd0,  0, 0, 1,   0, 3'b010, 1, 0, 1);
    step("stl_resume",  0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b010, 1, 0, 1);
    step("stl_wb",      0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b100, 0, 1, 1);
    // Stall while in writeback: counted once, when en returns.
    step("wbs_issue",   0, 1, 0, 1, 5'd15, 0, 1, 1,   1, 3'b000, 1, 0, 2);
    step("wbs_ex",      0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b001, 1, 0, 2);
    step("wbs_mem",     0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b010, 1, 0, 2);
    step("wbs_hold1",   0, 0, 0, 0, 5'd0,  0, 0, 1,   0, 3'b100, 0, 1, 2);
    step("wbs_hold2",   0, 0, 0, 0, 5'd0,  0, 0, 1,   0, 3'b100, 0, 1, 2);
    step("wbs_go",      0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b100, 0, 1, 2);
    // Flush during stall clears stage 0.
    step("fl_issue",    0, 1, 0, 1, 5'd0,  1, 0, 1,   1, 3'b000, 1, 0, 3);
    step("fl_stall",    0, 0, 1, 0, 5'd0,  0, 0, 1,   0, 3'b001, 1, 0, 3);
    step("fl_cleared",  0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b000, 0, 0, 3);
    // Reset mid-flight with pipe=110.
    step("rf_issue1",   0, 1, 0, 1, 5'd0,  1, 0, 1,   1, 3'b000, 1, 0, 3);
    step("rf_issue2",   0, 1, 0, 1, 5'd0,  1, 0, 1,   1, 3'b001, 1, 0, 3);
    step("rf_fill",     0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b011, 1, 0, 3);
    step("rf_110",      0, 0, 0, 0, 5'd0,  0, 0, 1,   0, 3'b110, 1, 1, 3);
    step("rf_reset",    1, 0, 0, 0, 5'd0,  0, 0, 1,   0, 3'b000, 0, 0, 0);
    step("rf_release",  0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b000, 0, 0, 0);
    // Six back-to-back redirects; the 2-bit counter saturates at 3.
    step("sat_i1",      0, 1, 0, 1, 5'd0,  1, 0, 1,   1, 3'b000, 1, 0, 0);
    step("sat_i2",      0, 1, 0, 1, 5'd0,  1, 0, 1,   1, 3'b001, 1, 0, 0);
    step("sat_i3",      0, 1, 0, 1, 5'd0,  1, 0, 1,   1, 3'b011, 1, 0, 0);
    step("sat_i4",      0, 1, 0, 1, 5'd0,  1, 0, 1,   1, 3'b111, 1, 1, 0);
    step("sat_i5",      0, 1, 0, 1, 5'd0,  1, 0, 1,   1, 3'b111, 1, 1, 1);
    step("sat_i6",      0, 1, 0, 1, 5'd0,  1, 0, 1,   1, 3'b111, 1, 1, 2);
    step("sat_d1",      0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b111, 1, 1, 3);
    step("sat_d2",      0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b110, 1, 1, 4);
    step("sat_d3",      0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b100, 0, 1, 5);
    step("sat_end",     0, 1, 0, 0, 5'd0,  0, 0, 1,   0, 3'b000, 0, 0, 6);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: scoreboard left=%0d, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
